// File: rtl/dff_reg_pkg.sv
// dff_reg_pkg: shared op codes, FSM states and counter widths
// for the round-robin arbitrated D-flip-flop register block.
package dff_reg_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_PRE  = 2'b10;
  localparam logic [1:0] OP_HOLD = 2'b11;

  localparam int NREQ_MAX = 8;
  localparam int PTR_W    = $clog2(NREQ_MAX);
  localparam int CNT_W    = 3;
  localparam int RTY_W    = 4;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    DRIVE,
    VERIFY,
    ACK
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick; search starts at ptr.
// Ports: req vector, ptr in; one-hot win, its idx and any out.
module rr_pick
  import dff_reg_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  win,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any && req[(int'(ptr) + k) % NREQ]) begin
        any = 1'b1;
        win[(int'(ptr) + k) % NREQ] = 1'b1;
        idx = PTR_W'((int'(ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/dff_reg_arbiter.sv
// dff_reg_arbiter: NREQ requesters share one WIDTH-bit DFF register
// (load/clear/preset/hold), served round-robin; shadow drives dff_d.
// Ports: clk, clr (async low), req/op/din, q_in in; gnt, ack,
// dff_d, dff_clr, dff_pre, busy, err out. Macro DFF_REG_VERIFY_EN
// adds readback verify with retry and a sticky err flag.
module dff_reg_arbiter
  import dff_reg_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int PULSE_CYC = 2,
  parameter int MAX_RETRY = 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     op,
  input  logic [NREQ*WIDTH-1:0] din,
  input  logic [WIDTH-1:0]      q_in,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      dff_d,
  output logic                  dff_clr,
  output logic                  dff_pre,
  output logic                  busy,
  output logic                  err
);

  state_t            state, state_n;
  logic [PTR_W-1:0]  ptr, ptr_n;
  logic [NREQ-1:0]   gnt_n;
  logic [1:0]        op_r, op_n, op_sel;
  logic [WIDTH-1:0]  din_r, din_n, din_sel;
  logic [WIDTH-1:0]  shadow, shadow_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [NREQ-1:0]   win;
  logic [PTR_W-1:0]  win_idx;
  logic              win_any;
  logic              drv_done;

`ifdef DFF_REG_VERIFY_EN
  logic [RTY_W-1:0]  rty, rty_n;
  logic              err_q, err_set;
`else
  logic              unused_ok;
  assign unused_ok = ^{q_in, MAX_RETRY[0]};
`endif

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req),
    .ptr (ptr),
    .win (win),
    .idx (win_idx),
    .any (win_any)
  );

  always_comb begin
    op_sel  = OP_HOLD;
    din_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        op_sel  = op[2*i +: 2];
        din_sel = din[WIDTH*i +: WIDTH];
      end
    end
  end

  assign drv_done = (op_r == OP_LOAD) ||
                    (cnt == CNT_W'(PULSE_CYC - 1));

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    gnt_n    = gnt;
    op_n     = op_r;
    din_n    = din_r;
    shadow_n = shadow;
    cnt_n    = cnt;
`ifdef DFF_REG_VERIFY_EN
    rty_n    = rty;
    err_set  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (|req) state_n = ARB;
      end
      ARB: begin
        if (gnt == '0) begin
          if (win_any) begin
            gnt_n = win;
            ptr_n = (win_idx == PTR_W'(NREQ - 1)) ?
                    '0 : win_idx + 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else if (!(|(req & gnt))) begin
          gnt_n   = '0;
          state_n = IDLE;
        end else begin
          op_n  = op_sel;
          din_n = din_sel;
          cnt_n = '0;
`ifdef DFF_REG_VERIFY_EN
          rty_n = '0;
`endif
          state_n = (op_sel == OP_HOLD) ? ACK : DRIVE;
        end
      end
      DRIVE: begin
        if (drv_done) begin
          cnt_n = '0;
          unique case (op_r)
            OP_LOAD: shadow_n = din_r;
            OP_CLR:  shadow_n = '0;
            OP_PRE:  shadow_n = '1;
            default: shadow_n = shadow;
          endcase
`ifdef DFF_REG_VERIFY_EN
          state_n = VERIFY;
`else
          state_n = ACK;
`endif
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef DFF_REG_VERIFY_EN
      VERIFY: begin
        if (q_in == shadow) begin
          state_n = ACK;
        end else if (rty < RTY_W'(MAX_RETRY)) begin
          rty_n   = rty + 1'b1;
          cnt_n   = '0;
          state_n = DRIVE;
        end else begin
          err_set = 1'b1;
          state_n = ACK;
        end
      end
`endif
      ACK: begin
        gnt_n   = '0;
        state_n = IDLE;
      end
      default: begin
        gnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      ack     <= '0;
      op_r    <= OP_HOLD;
      din_r   <= '0;
      shadow  <= '0;
      cnt     <= '0;
      dff_clr <= 1'b1;
      dff_pre <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      gnt     <= gnt_n;
      ack     <= (state_n == ACK) ? gnt_n : '0;
      op_r    <= op_n;
      din_r   <= din_n;
      shadow  <= shadow_n;
      cnt     <= cnt_n;
      dff_clr <= !(state_n == DRIVE && op_n == OP_CLR);
      dff_pre <= !(state_n == DRIVE && op_n == OP_PRE);
      busy    <= (state_n != IDLE);
    end
  end

  assign dff_d = shadow;

`ifdef DFF_REG_VERIFY_EN
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rty   <= '0;
      err_q <= 1'b0;
    end else begin
      rty   <= rty_n;
      err_q <= err_q | err_set;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// tb_dff_reg_arbiter: directed + random transactions against a
// transaction-level model of the arbitrated DFF register.
module tb_dff_reg_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int P    = 2;
  localparam int MR   = 1;
`ifdef DFF_REG_VERIFY_EN
  localparam int VEN  = 1;
`else
  localparam int VEN  = 0;
`endif

  logic            clk = 1'b0;
  logic            clr;
  logic [NREQ-1:0] req;
  logic [2*NREQ-1:0] op;
  logic [NREQ*W-1:0] din;
  logic [W-1:0]    q_in;
  logic [NREQ-1:0] gnt, ack;
  logic [W-1:0]    dff_d;
  logic            dff_clr, dff_pre, busy, err;
  logic            stuck;

  int checks = 0;
  int errors = 0;

  int       ptr_m;
  logic [7:0] reg_m;
  logic     err_m;

  assign q_in = stuck ? 8'h00 : dff_d;

  always #5 clk = ~clk;

  dff_reg_arbiter #(
    .NREQ(NREQ), .WIDTH(W), .PULSE_CYC(P), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .clr(clr), .req(req), .op(op), .din(din),
    .q_in(q_in), .gnt(gnt), .ack(ack), .dff_d(dff_d),
    .dff_clr(dff_clr), .dff_pre(dff_pre), .busy(busy), .err(err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_m(input logic [3:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // mode 0: winner drops; 1: winner drops then re-requests; 2: all drop
  task automatic run_txn(input int mode);
    int w, k, lat, nclr, npre, both, passes, dlen, exp_lat;
    logic [1:0] o;
    logic [7:0] v;
    bit mism;
    w = pick_m(req, ptr_m);
    k = 0;
    while (1) begin
      @(negedge clk);
      k++;
      if (gnt != 0 || k >= 12) break;
    end
    chk("gnt_lat", k, 2);
    chk("gnt_winner", 32'(gnt), 32'(1 << w));
    if (gnt == 0) return;
    o = op[2*w +: 2];
    v = din[8*w +: 8];
    case (o)
      2'b01:   v = 8'h00;
      2'b10:   v = 8'hFF;
      2'b11:   v = reg_m;
      default: ;
    endcase
    mism    = (VEN == 1) && stuck && (v != 8'h00) && (o != 2'b11);
    passes  = mism ? 1 + MR : 1;
    dlen    = (o == 2'b00) ? 1 : P;
    exp_lat = (o == 2'b11) ? 1 : 1 + passes * (dlen + VEN);
    lat = 0; nclr = 0; npre = 0; both = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (!dff_clr) nclr++;
      if (!dff_pre) npre++;
      if (!dff_clr && !dff_pre) both++;
      if (ack != 0 || lat >= 60) break;
    end
    chk("ack_onehot", 32'(ack), 32'(1 << w));
    chk("ack_lat", lat, exp_lat);
    chk("clr_pulse", nclr, (o == 2'b01) ? passes * P : 0);
    chk("pre_pulse", npre, (o == 2'b10) ? passes * P : 0);
    chk("both_low", both, 0);
    chk("dff_d", 32'(dff_d), 32'(v));
    reg_m = v;
    if (mism) err_m = 1'b1;
    chk("err", 32'(err), 32'(err_m));
    ptr_m = (w + 1) % NREQ;
    if (mode == 2) req = '0;
    else req[w] = 1'b0;
    @(negedge clk);
    chk("idle_gnt", 32'(gnt), 0);
    chk("idle_ack", 32'(ack), 0);
    chk("idle_busy", 32'(busy), 0);
    if (mode == 1) req[w] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [7:0] d0;
    clr = 1'b0; stuck = 1'b0;
    req = 4'b1111; op = '0; din = '0;
    ptr_m = 0; reg_m = 8'h00; err_m = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_clr", 32'(dff_clr), 1);
    chk("rst_pre", 32'(dff_pre), 1);
    chk("rst_d", 32'(dff_d), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);

    // round robin, all four requesting, each re-requests after ack
    for (int i = 0; i < NREQ; i++) din[8*i +: 8] = 8'(8'h10 + i);
    clr = 1'b1;
    for (int n = 0; n < 5; n++) run_txn(1);
    req = '0;
    @(negedge clk);

    // load A5 from requester 1
    op[3:2] = 2'b00; din[15:8] = 8'hA5;
    req = 4'b0010;
    run_txn(2);

    // preset then clear from requester 2
    op[5:4] = 2'b10; req = 4'b0100;
    run_txn(2);
    op[5:4] = 2'b01; req = 4'b0100;
    run_txn(2);

    // withdrawal during ARB
    op[7:6] = 2'b00; din[31:24] = 8'h77;
    d0 = dff_d;
    req = 4'b1000;
    @(negedge clk);
    @(negedge clk);
    chk("wd_gnt", 32'(gnt), 32'h8);
    req = '0;
    @(negedge clk);
    chk("wd_gnt0", 32'(gnt), 0);
    chk("wd_busy", 32'(busy), 0);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack != 0 || busy) seen++;
    end
    chk("wd_noack", seen, 0);
    chk("wd_d", 32'(dff_d), 32'(d0));
    ptr_m = 0;

    // withdrawal during DRIVE still completes
    op[7:6] = 2'b10; req = 4'b1000;
    @(negedge clk);
    @(negedge clk);
    chk("dd_gnt", 32'(gnt), 32'h8);
    @(negedge clk);
    chk("dd_pre_low", 32'(dff_pre), 0);
    req = '0;
    seen = 0;
    while (ack == 0 && seen < 30) begin
      @(negedge clk);
      seen++;
    end
    chk("dd_ack", 32'(ack), 32'h8);
    chk("dd_d", 32'(dff_d), 32'hFF);
    reg_m = 8'hFF; ptr_m = 0;
    @(negedge clk);

    // randomized transactions
    for (int n = 0; n < 20; n++) begin
      op  = 8'($urandom);
      din = $urandom;
      req = 4'($urandom_range(1, 15));
      run_txn(2);
    end

    // readback stuck at zero during load of 3C
    stuck = 1'b1;
    op[1:0] = 2'b00; din[7:0] = 8'h3C; req = 4'b0001;
    run_txn(2);
    stuck = 1'b0;
    op[3:2] = 2'b00; din[15:8] = 8'h5A; req = 4'b0010;
    run_txn(2);

    // reset in the middle of a clear pulse
    op[1:0] = 2'b01; req = 4'b0001;
    if (ptr_m != 0) begin
      req = 4'b0001;
    end
    @(negedge clk);
    @(negedge clk);
    chk("mr_gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    chk("mr_clr_low", 32'(dff_clr), 0);
    #2 clr = 1'b0;
    #1;
    chk("mr_clr", 32'(dff_clr), 1);
    chk("mr_gnt0", 32'(gnt), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_d", 32'(dff_d), 0);
    chk("mr_err", 32'(err), 0);
    req = '0;
    ptr_m = 0; reg_m = 8'h00; err_m = 1'b0;
    @(negedge clk);
    clr = 1'b1;

    // after reset requester 0 wins again over 2
    op[5:4] = 2'b00; din[23:16] = 8'hC3;
    op[1:0] = 2'b00; din[7:0] = 8'h81;
    req = 4'b0101;
    run_txn(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
